// File: rtl/rv_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback, long-latency FIFO, busy scoreboard.
// Optional starvation guard enabled by defining RV_WB_ARB_STARVE_GUARD_EN.
module rv_wb_arbiter #(
  parameter int PEND_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_write,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_ll_issue,
  input  logic [4:0]  i_ll_issue_rd,
  input  logic        i_ll_valid,
  output logic        o_ll_ready,
  input  logic [4:0]  i_ll_rd,
  input  logic [31:0] i_ll_data,
  output logic        o_rf_write,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_data,
  output logic [31:0] o_busy,
  output logic        o_wb_hold
);

  localparam int AW = $clog2(PEND_DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [4:0]    r_q_rd   [PEND_DEPTH];
  logic [31:0]   r_q_data [PEND_DEPTH];
  logic          r_rf_write;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_data;
  logic [31:0]   r_busy;

  logic        w_full;
  logic        w_empty;
  logic        w_xfer;
  logic        w_wb_win;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic        w_ll_wr;
  logic [4:0]  w_ll_rd;
  logic        w_wr;
  logic [4:0]  w_wr_rd;
  logic [31:0] w_wr_data;
  logic [31:0] w_busy_nxt;

  assign w_full     = (r_count == (AW+1)'(PEND_DEPTH));
  assign w_empty    = (r_count == '0);
  assign o_ll_ready = !w_full && !i_reset;
  assign w_xfer     = i_ll_valid && o_ll_ready;

  assign w_wb_win = i_wb_write && (i_wb_rd != 5'd0) && !o_wb_hold;
  assign w_pop    = !w_wb_win && !w_empty;
  assign w_bypass = !w_wb_win && w_empty && w_xfer;
  // x0 results are accepted but never stored
  assign w_push   = w_xfer && !w_bypass && (i_ll_rd != 5'd0);

  assign w_ll_wr = w_pop || (w_bypass && (i_ll_rd != 5'd0));
  assign w_ll_rd = w_pop ? r_q_rd[r_rptr] : i_ll_rd;

  always_comb begin
    w_wr      = 1'b0;
    w_wr_rd   = r_rf_rd;
    w_wr_data = r_rf_data;
    if (w_wb_win) begin
      w_wr      = 1'b1;
      w_wr_rd   = i_wb_rd;
      w_wr_data = i_wb_data;
    end else if (w_ll_wr) begin
      w_wr      = 1'b1;
      w_wr_rd   = w_ll_rd;
      w_wr_data = w_pop ? r_q_data[r_rptr] : i_ll_data;
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ll_wr)
      w_busy_nxt[w_ll_rd] = 1'b0;
    if (i_ll_issue && (i_ll_issue_rd != 5'd0))
      w_busy_nxt[i_ll_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rf_write <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_data  <= 32'd0;
      r_busy     <= 32'd0;
    end else begin
      if (w_push) begin
        r_q_rd[r_wptr]   <= i_ll_rd;
        r_q_data[r_wptr] <= i_ll_data;
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
      r_rf_write <= w_wr;
      r_rf_rd    <= w_wr_rd;
      r_rf_data  <= w_wr_data;
      r_busy     <= w_busy_nxt;
    end
  end

`ifdef RV_WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_nxt;
  logic          r_hold;

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop)
      w_starve_nxt = '0;
    else if (!w_empty && w_wb_win && (r_starve != SW'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve <= '0;
      r_hold   <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_hold   <= !r_hold && (w_starve_nxt == SW'(STARVE_LIMIT));
    end
  end

  assign o_wb_hold = r_hold;
`else
  assign o_wb_hold = 1'b0;
`endif

  assign o_rf_write = r_rf_write;
  assign o_rf_rd    = r_rf_rd;
  assign o_rf_data  = r_rf_data;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench for rv_wb_arbiter: reset, bypass, conflict, full FIFO,
// scoreboard, x0 handling and starvation window.
module tb_rv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        rf_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] busy;
  logic        wb_hold;

  int ntests = 0;
  int nfail  = 0;
  logic exp_hold;

  always #5 clk = ~clk;

  rv_wb_arbiter dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_wb_write    (wb_write),
    .i_wb_rd       (wb_rd),
    .i_wb_data     (wb_data),
    .i_ll_issue    (ll_issue),
    .i_ll_issue_rd (ll_issue_rd),
    .i_ll_valid    (ll_valid),
    .o_ll_ready    (ll_ready),
    .i_ll_rd       (ll_rd),
    .i_ll_data     (ll_data),
    .o_rf_write    (rf_write),
    .o_rf_rd       (rf_rd),
    .o_rf_data     (rf_data),
    .o_busy        (busy),
    .o_wb_hold     (wb_hold)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_write), 32'd1);
    chk({tag, "_rd"}, 32'(rf_rd), 32'(rd));
    chk({tag, "_data"}, rf_data, d);
  endtask

  task automatic idle();
    wb_write = 0; wb_rd = 0; wb_data = 0;
    ll_issue = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    // reset with random stimulus
    for (int i = 0; i < 3; i++) begin
      wb_write = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      ll_issue = 1'($urandom); ll_issue_rd = 5'($urandom);
      ll_valid = 1'($urandom); ll_rd = 5'($urandom); ll_data = $urandom;
      tick();
    end
    chk("rst_we", 32'(rf_write), 0);
    chk("rst_rd", 32'(rf_rd), 0);
    chk("rst_data", rf_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", 32'(wb_hold), 0);
    chk("rst_ready", 32'(ll_ready), 0);
    idle();
    rst = 0;
    #1;
    chk("post_rst_ready", 32'(ll_ready), 1);
    tick();
    chk("idle_we", 32'(rf_write), 0);

    // bypass
    ll_valid = 1; ll_rd = 5; ll_data = 32'hDEADBEEF;
    tick();
    idle();
    chk_wr("byp", 5, 32'hDEADBEEF);
    tick();
    chk("byp_empty_we", 32'(rf_write), 0);
    chk("byp_hold_rd", 32'(rf_rd), 5);

    // conflict: pipeline first, then queued result
    wb_write = 1; wb_rd = 3; wb_data = 32'h11;
    ll_valid = 1; ll_rd = 7; ll_data = 32'h22;
    tick();
    idle();
    chk_wr("cf1", 3, 32'h11);
    tick();
    chk_wr("cf2", 7, 32'h22);
    tick();
    chk("cf_idle_we", 32'(rf_write), 0);
    chk("cf_idle_data", rf_data, 32'h22);

    // full FIFO under continuous writeback
    wb_write = 1; wb_rd = 1; wb_data = 32'hA1;
    ll_valid = 1; ll_rd = 10; ll_data = 32'h100;
    chk("full_rdy0", 32'(ll_ready), 1);
    tick();
    chk_wr("full_wb1", 1, 32'hA1);
    wb_data = 32'hA2; ll_rd = 11; ll_data = 32'h101;
    #1;
    chk("full_rdy1", 32'(ll_ready), 1);
    tick();
    chk_wr("full_wb2", 1, 32'hA2);
    wb_data = 32'hA3; ll_rd = 12; ll_data = 32'h102;
    #1;
    chk("full_rdy2", 32'(ll_ready), 0);
    tick();
    chk_wr("full_wb3", 1, 32'hA3);
    wb_write = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("full_rdy3", 32'(ll_ready), 0);
    tick();
    chk_wr("full_q0", 10, 32'h100);
    chk("full_rdy4", 32'(ll_ready), 1);
    tick();
    chk_wr("full_q1", 11, 32'h101);
    idle();
    tick();
    chk_wr("full_q2", 12, 32'h102);
    tick();
    chk("full_done_we", 32'(rf_write), 0);

    // scoreboard
    ll_issue = 1; ll_issue_rd = 9;
    tick();
    idle();
    chk("sb_set", busy, 32'h200);
    ll_valid = 1; ll_rd = 9; ll_data = 32'h99;
    tick();
    idle();
    chk_wr("sb_ret", 9, 32'h99);
    chk("sb_clr", busy, 0);
    ll_issue = 1; ll_issue_rd = 9;
    tick();
    chk("sb_set2", busy, 32'h200);
    ll_valid = 1; ll_rd = 9; ll_data = 32'h98;
    tick();
    idle();
    chk_wr("sb_same", 9, 32'h98);
    chk("sb_setwins", busy, 32'h200);
    ll_valid = 1; ll_rd = 9; ll_data = 32'h97;
    ll_issue = 1; ll_issue_rd = 0;
    tick();
    idle();
    chk("sb_clr2", busy, 0);

    // x0 handling
    ll_issue = 1; ll_issue_rd = 4;
    tick();
    idle();
    ll_valid = 1; ll_rd = 0; ll_data = 32'h55;
    tick();
    idle();
    chk("x0_ll_we", 32'(rf_write), 0);
    chk("x0_ll_busy", busy, 32'h10);
    wb_write = 1; wb_rd = 0; wb_data = 32'h66;
    ll_valid = 1; ll_rd = 6; ll_data = 32'h77;
    tick();
    idle();
    chk_wr("x0_wb_free", 6, 32'h77);
    ll_valid = 1; ll_rd = 4; ll_data = 32'h44;
    tick();
    idle();
    chk("x0_busy_clr", busy, 0);

    // starvation window: head waits behind writeback
    wb_write = 1; wb_rd = 2; wb_data = 32'hB0;
    ll_valid = 1; ll_rd = 13; ll_data = 32'hC13;
    tick();
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    chk_wr("st_wb0", 2, 32'hB0);
    for (int i = 1; i < 5; i++) begin
      wb_data = 32'hB0 + 32'(i);
      tick();
      chk_wr("st_wb", 2, 32'hB0 + 32'(i));
    end
`ifdef RV_WB_ARB_STARVE_GUARD_EN
    exp_hold = 1'b1;
`else
    exp_hold = 1'b0;
`endif
    chk("st_hold", 32'(wb_hold), 32'(exp_hold));
    idle();
    tick();
    chk_wr("st_head", 13, 32'hC13);
    chk("st_hold_end", 32'(wb_hold), 0);
    tick();
    chk("st_idle_we", 32'(rf_write), 0);

    // reset mid-operation drops queue and busy bits
    ll_issue = 1; ll_issue_rd = 8;
    wb_write = 1; wb_rd = 1; wb_data = 32'hE0;
    ll_valid = 1; ll_rd = 8; ll_data = 32'hE8;
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("mid_rst_we", 32'(rf_write), 0);
    chk("mid_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
